// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
//
// Round-robin arbiter that shares one single-port SRAM (valid/ready handshake,
// one-cycle access) among NUM_REQ requesters. One requester is granted at a
// time. The arbiter drives a one-cycle memory request, waits for the memory's
// ready, then returns read data or a write acknowledge to that requester.
// This block is the only driver of the memory request port.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, the response wait is bounded to TIMEOUT_CYC cycles. On
//   expiry the transaction completes with rsp_err_o=1 and rsp_rdata_o=0.
//   When undefined, the arbiter waits for ready indefinitely and rsp_err_o
//   is tied to 0.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   DEPTH        memory depth
//   WIDTH        data width
//   ADDR_WIDTH   address width
//   TIMEOUT_CYC  response wait limit (used only with ARB_TIMEOUT_EN)
//
// Ports
//   clk_i         clock, rising edge
//   clr_i         asynchronous active-high reset
//   req_valid_i   per-requester request valid
//   req_wr_i      per-requester direction (1=write, 0=read)
//   req_addr_i    packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata_i   packed write data, requester k at [k*WIDTH +: WIDTH]
//   req_ready_o   one-hot one-cycle pulse: request accepted
//   rsp_valid_o   one-hot one-cycle pulse: transaction complete
//   rsp_rdata_o   read data, valid with rsp_valid_o on reads
//   rsp_err_o     timeout error, valid with rsp_valid_o
//   m_valid_o     memory request valid
//   m_wr_rd_en_o  memory direction
//   m_addr_o      memory address
//   m_wdata_o     memory write data
//   m_rdata_i     memory read data
//   m_ready_i     memory ready
// -----------------------------------------------------------------------------
module mem_rr_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DEPTH       = 16,
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                          clk_i,
  input  logic                          clr_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_wr_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [WIDTH-1:0]              rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          m_valid_o,
  output logic                          m_wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0]         m_addr_o,
  output logic [WIDTH-1:0]              m_wdata_o,
  input  logic [WIDTH-1:0]              m_rdata_i,
  input  logic                          m_ready_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject parameter sets the arbiter is not built for.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || ADDR_WIDTH < 1 ||
      DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("mem_rr_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state_reg,     state_next;
  logic [IDX_W-1:0]       ptr_reg,       ptr_next;     // last completed grant
  logic [IDX_W-1:0]       gnt_reg,       gnt_next;     // requester in flight
  logic [NUM_REQ-1:0]     req_ready_reg, req_ready_next;
  logic [NUM_REQ-1:0]     rsp_valid_reg, rsp_valid_next;
  logic [WIDTH-1:0]       rsp_rdata_reg, rsp_rdata_next;
  logic                   m_valid_reg,   m_valid_next;
  logic                   m_wr_reg,      m_wr_next;
  logic [ADDR_WIDTH-1:0]  m_addr_reg,    m_addr_next;
  logic [WIDTH-1:0]       m_wdata_reg,   m_wdata_next;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0]       cnt_reg,       cnt_next;
  logic                   rsp_err_reg,   rsp_err_next;
`endif

  // ---------------------------------------------------------------------------
  // Unpack per-requester request fields
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [WIDTH-1:0]      wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata_i[gi*WIDTH +: WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Round-robin scan: slot gi looks at requester (ptr + 1 + gi) mod NUM_REQ,
  // so slot 0 is the highest-priority candidate for this pass.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
    logic [IDX_W:0] sum;
    assign sum      = {1'b0, ptr_reg} + (IDX_W+1)'(gi + 1);
    // sum never reaches 2*NUM_REQ, so a single conditional subtract wraps it.
    assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                      IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
    assign hit[gi]  = req_valid_i[cand[gi]];
  end

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  // Lowest set slot wins; walking downwards lets the lowest overwrite last.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pick_any = 1'b1;
        pick_idx = cand[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= IDX_W'(NUM_REQ - 1);  // requester 0 goes first
      gnt_reg       <= '0;
      req_ready_reg <= '0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      m_valid_reg   <= 1'b0;
      m_wr_reg      <= 1'b0;
      m_addr_reg    <= '0;
      m_wdata_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gnt_reg       <= gnt_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      m_valid_reg   <= m_valid_next;
      m_wr_reg      <= m_wr_next;
      m_addr_reg    <= m_addr_next;
      m_wdata_reg   <= m_wdata_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      cnt_reg     <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      rsp_err_reg <= rsp_err_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_next       = gnt_reg;
    req_ready_next = '0;
    rsp_valid_next = '0;
    rsp_rdata_next = rsp_rdata_reg;
    m_valid_next   = 1'b0;
    m_wr_next      = m_wr_reg;
    m_addr_next    = m_addr_reg;
    m_wdata_next   = m_wdata_reg;
`ifdef ARB_TIMEOUT_EN
    cnt_next       = cnt_reg;
    rsp_err_next   = rsp_err_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_next                 = pick_idx;
          m_wr_next                = req_wr_i[pick_idx];
          m_addr_next              = addr_arr[pick_idx];
          m_wdata_next             = wdata_arr[pick_idx];
          req_ready_next[pick_idx] = 1'b1;
          m_valid_next             = 1'b1;
          state_next               = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // m_valid drops by default: the memory sees exactly one request cycle.
        state_next = ST_RESP;
`ifdef ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
      end

      ST_RESP: begin
        if (m_ready_i) begin
          rsp_valid_next[gnt_reg] = 1'b1;
          if (!m_wr_reg) begin
            rsp_rdata_next = m_rdata_i;
          end
          ptr_next   = gnt_reg;
          state_next = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
          rsp_err_next = 1'b0;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Last allowed wait cycle passed without ready: fail the access.
          rsp_valid_next[gnt_reg] = 1'b1;
          rsp_rdata_next          = '0;
          rsp_err_next            = 1'b1;
          ptr_next                = gnt_reg;
          state_next              = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
`endif
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready_o  = req_ready_reg;
  assign rsp_valid_o  = rsp_valid_reg;
  assign rsp_rdata_o  = rsp_rdata_reg;
  assign m_valid_o    = m_valid_reg;
  assign m_wr_rd_en_o = m_wr_reg;
  assign m_addr_o     = m_addr_reg;
  assign m_wdata_o    = m_wdata_reg;
`ifdef ARB_TIMEOUT_EN
  assign rsp_err_o    = rsp_err_reg;
`else
  assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_rr_arbiter
//
// Scoreboard bench for mem_rr_arbiter with four requesters. The stimulus
// process pushes hand-computed expected grants and responses into queues; a
// monitor on the falling clock edge pops and compares them whenever the
// arbiter pulses req_ready or rsp_valid. A small behavioural SRAM serves the
// memory port.
// -----------------------------------------------------------------------------
module tb_mem_rr_arbiter;

  localparam int NR    = 4;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clr;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_wr;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              m_valid;
  logic              m_wr;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic [DW-1:0]     m_rdata;
  logic              m_ready;

  mem_rr_arbiter #(
    .NUM_REQ    (NR),
    .DEPTH      (DEPTH),
    .WIDTH      (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i       (clk),
    .clr_i       (clr),
    .req_valid_i (req_valid),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .m_valid_o   (m_valid),
    .m_wr_rd_en_o(m_wr),
    .m_addr_o    (m_addr),
    .m_wdata_o   (m_wdata),
    .m_rdata_i   (m_rdata),
    .m_ready_i   (m_ready)
  );

  // ---------------------------------------------------------------------------
  // Behavioural SRAM: one-cycle access, ready follows a sampled valid.
  // mem_stall suppresses both the access and the ready.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  logic          mem_stall;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    m_rdata = '0;
    m_ready = 1'b0;
  end

  always @(posedge clk) begin
    if (m_valid && !mem_stall) begin
      if (m_wr) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
      m_ready <= 1'b1;
    end else begin
      m_ready <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [NR-1:0] onehot;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic [NR-1:0] onehot;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [30:0] all_out;
  assign all_out = {req_ready, rsp_valid, rsp_rdata, rsp_err,
                    m_valid, m_wr, m_addr, m_wdata};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_gnt(input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    gnt_t g;
    g.onehot    = '0;
    g.onehot[k] = 1'b1;
    g.wr        = wr;
    g.addr      = a;
    g.wdata     = d;
    gnt_q.push_back(g);
  endtask

  task automatic exp_rsp(input int k, input logic [DW-1:0] rd, input logic err);
    rsp_t r;
    r.onehot    = '0;
    r.onehot[k] = 1'b1;
    r.rdata     = rd;
    r.err       = err;
    rsp_q.push_back(r);
  endtask

  // Monitor
  gnt_t mon_g;
  rsp_t mon_r;
  logic prev_mv = 1'b0;

  always @(negedge clk) begin
    if (req_ready != '0) begin
      if (gnt_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_grant: got req_ready=%b required none", req_ready);
      end else begin
        mon_g = gnt_q.pop_front();
        chk("grant", {m_valid, req_ready, m_wr, m_addr, m_wdata},
            {1'b1, mon_g.onehot, mon_g.wr, mon_g.addr, mon_g.wdata});
      end
    end
    if (rsp_valid != '0) begin
      $display("rsp: req_onehot=%b rdata=%02h err=%b", rsp_valid, rsp_rdata, rsp_err);
      if (rsp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b required none", rsp_valid);
      end else begin
        mon_r = rsp_q.pop_front();
        chk("response", {rsp_valid, rsp_rdata, rsp_err},
            {mon_r.onehot, mon_r.rdata, mon_r.err});
      end
    end
    if (m_valid) chk("m_valid_one_cycle", {63'd0, prev_mv}, 64'd0);
    prev_mv <= m_valid;
  end

  // ---------------------------------------------------------------------------
  // Requester agents: hold a request until it has been accepted rem[k] times.
  // ---------------------------------------------------------------------------
  int rem [NR];

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int n);
    req_wr[k]            = wr;
    req_addr[k*AW +: AW] = a;
    req_wdata[k*DW +: DW] = d;
    rem[k]               = n;
    req_valid[k]         = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      if (req_ready[k] && rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0) req_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int max);
    int c = 0;
    while ((gnt_q.size() != 0 || rsp_q.size() != 0) && c < max) begin
      step();
      c++;
    end
    chk("drain_done", 64'(gnt_q.size() + rsp_q.size()), 64'd0);
    gnt_q.delete();
    rsp_q.delete();
    step();
  endtask

  task automatic wait_mvalid(input int max);
    int c = 0;
    step();
    while (!m_valid && c < max) begin
      step();
      c++;
    end
    chk("m_valid_seen", {63'd0, m_valid}, 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int   c;
    logic bad;
    clr       = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_stall = 1'b0;
    for (int k = 0; k < NR; k++) rem[k] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(all_out), 64'd0);
    clr = 1'b0;

    // Asynchronous clear while the memory request is on the bus
    exp_gnt(0, 1'b1, 4'd5, 8'h11);
    set_req(0, 1'b1, 4'd5, 8'h11, 1);
    wait_mvalid(10);
    #2 clr = 1'b1;
    #1 chk("clear_in_issue", 64'(all_out), 64'd0);
    step();
    step();
    clr = 1'b0;

    // First grant after reset goes to requester 0, then requester 1
    exp_gnt(0, 1'b1, 4'd3, 8'hA5);
    exp_gnt(1, 1'b1, 4'd4, 8'h44);
    exp_rsp(0, 8'h00, 1'b0);
    exp_rsp(1, 8'h00, 1'b0);
    set_req(0, 1'b1, 4'd3, 8'hA5, 1);
    set_req(1, 1'b1, 4'd4, 8'h44, 1);
    drain(40);

    // Read back addr 3
    exp_gnt(0, 1'b0, 4'd3, 8'h00);
    exp_rsp(0, 8'hA5, 1'b0);
    set_req(0, 1'b0, 4'd3, 8'h00, 1);
    drain(40);

    // Contention, pointer at 0: grants alternate 1,0,1,0
    for (int i = 0; i < 2; i++) begin
      exp_gnt(1, 1'b0, 4'd3, 8'h00);
      exp_gnt(0, 1'b1, 4'd1, 8'h3C);
      exp_rsp(1, 8'hA5, 1'b0);
      exp_rsp(0, 8'hA5, 1'b0);
    end
    set_req(0, 1'b1, 4'd1, 8'h3C, 2);
    set_req(1, 1'b0, 4'd3, 8'h00, 2);
    drain(60);

    // Move the pointer to 3 with a single requester-3 write
    exp_gnt(3, 1'b1, 4'd7, 8'h77);
    exp_rsp(3, 8'hA5, 1'b0);
    set_req(3, 1'b1, 4'd7, 8'h77, 1);
    drain(40);

    // All four valid: grant order 0,1,2,3,0
    exp_gnt(0, 1'b0, 4'd7, 8'h00);
    exp_gnt(1, 1'b1, 4'd8, 8'h81);
    exp_gnt(2, 1'b0, 4'd3, 8'h00);
    exp_gnt(3, 1'b0, 4'd1, 8'h00);
    exp_gnt(0, 1'b0, 4'd7, 8'h00);
    exp_rsp(0, 8'h77, 1'b0);
    exp_rsp(1, 8'h77, 1'b0);
    exp_rsp(2, 8'hA5, 1'b0);
    exp_rsp(3, 8'h3C, 1'b0);
    exp_rsp(0, 8'h77, 1'b0);
    set_req(0, 1'b0, 4'd7, 8'h00, 2);
    set_req(1, 1'b1, 4'd8, 8'h81, 1);
    set_req(2, 1'b0, 4'd3, 8'h00, 1);
    set_req(3, 1'b0, 4'd1, 8'h00, 1);
    drain(80);

    // Lone requester 2: accepted on the next IDLE, response three cycles on
    exp_gnt(2, 1'b1, 4'd2, 8'h22);
    exp_rsp(2, 8'h77, 1'b0);
    set_req(2, 1'b1, 4'd2, 8'h22, 1);
    step();
    chk("idle_grant_latency", 64'(req_ready), 64'h4);
    step();
    step();
    chk("rsp_latency", 64'(rsp_valid), 64'h4);
    drain(20);

    // Pointer to 3, then clear during RESP: no response, requester 0 first
    exp_gnt(3, 1'b0, 4'd7, 8'h00);
    exp_rsp(3, 8'h77, 1'b0);
    set_req(3, 1'b0, 4'd7, 8'h00, 1);
    drain(40);
    exp_gnt(0, 1'b1, 4'd9, 8'h99);
    set_req(0, 1'b1, 4'd9, 8'h99, 1);
    wait_mvalid(10);
    step();
    #2 clr = 1'b1;
    #1 chk("clear_in_resp", 64'(all_out), 64'd0);
    step();
    step();
    clr = 1'b0;
    exp_gnt(0, 1'b0, 4'd3, 8'h00);
    exp_gnt(1, 1'b0, 4'd7, 8'h00);
    exp_rsp(0, 8'hA5, 1'b0);
    exp_rsp(1, 8'h77, 1'b0);
    set_req(0, 1'b0, 4'd3, 8'h00, 1);
    set_req(1, 1'b0, 4'd7, 8'h00, 1);
    drain(40);

    // Memory never answers
    mem_stall = 1'b1;
    exp_gnt(1, 1'b0, 4'd3, 8'h00);
`ifdef ARB_TIMEOUT_EN
    exp_rsp(1, 8'h00, 1'b1);
    set_req(1, 1'b0, 4'd3, 8'h00, 1);
    c = 0;
    do begin
      step();
      c++;
    end while (rsp_valid == '0 && c < 40);
    chk("timeout_latency", 64'(c), 64'd10);
    mem_stall = 1'b0;
    drain(20);
`else
    set_req(1, 1'b0, 4'd3, 8'h00, 1);
    step();
    set_req(0, 1'b0, 4'd3, 8'h00, 1);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp_valid != '0 || req_ready != '0 || m_valid) bad = 1'b1;
    end
    chk("stays_in_resp", {63'd0, bad}, 64'd0);
    clr       = 1'b1;
    req_valid = '0;
    for (int k = 0; k < NR; k++) rem[k] = 0;
    step();
    step();
    clr       = 1'b0;
    mem_stall = 1'b0;
    step();
`endif

    chk("gnt_queue_empty", 64'(gnt_q.size()), 64'd0);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "bench time limit");
  end

endmodule
